// File: rtl/spi_pixel_buffer_ctrl.sv
// Pixel buffer controller sitting behind the SPI slave interface.
// Decodes command bytes, stores pixel bytes in a single-port BRAM, runs
// in-place invert / saturating-add passes and streams the buffer back out.
module spi_pixel_buffer_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_in,
    input  logic       cmd_valid,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_free,
    output logic       busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ZERO = '0;
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    localparam logic [7:0] CMD_CLR_PTR = 8'h01;
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_INVERT  = 8'h04;
    localparam logic [7:0] CMD_ADD     = 8'h05;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WRITE    = 4'd1,
        S_ARG_WAIT = 4'd2,
        S_OP_RD    = 4'd3,
        S_OP_WAIT  = 4'd4,
        S_OP_WR    = 4'd5,
        S_RD_ADDR  = 4'd6,
        S_RD_WAIT  = 4'd7,
        S_RD_SEND  = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [7:0]        operand_q, operand_d;
    logic              op_add_q, op_add_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              data_out_valid_q, data_out_valid_d;
    logic              busy_q, busy_d;

    logic [7:0]        mem [0:DEPTH-1];
    logic [7:0]        mem_rdata_q;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;

    logic       cmd_clr;
    logic       cmd_accept;
    logic       data_ok;
    logic       send_ok;
    logic [8:0] add_sum;
    logic [7:0] op_result;

    // Shared decode terms; a byte arriving with a command is always dropped.
    always_comb begin
        cmd_clr    = cmd_valid && (cmd_in == CMD_CLR_PTR);
        cmd_accept = cmd_valid && ((state_q == S_IDLE) || (state_q == S_WRITE));
        data_ok    = data_valid && !cmd_valid;
        send_ok    = (state_q == S_RD_SEND) && data_out_free && !data_out_valid_q;
        add_sum    = {1'b0, mem_rdata_q} + {1'b0, operand_q};
        if (op_add_q) begin
            op_result = add_sum[8] ? 8'hFF : add_sum[7:0];
        end else begin
            op_result = 8'hFF - mem_rdata_q;
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            wr_ptr_q         <= PTR_ZERO;
            rd_ptr_q         <= PTR_ZERO;
            op_addr_q        <= PTR_ZERO;
            operand_q        <= 8'h00;
            op_add_q         <= 1'b0;
            data_out_q       <= 8'h00;
            data_out_valid_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            op_addr_q        <= op_addr_d;
            operand_q        <= operand_d;
            op_add_q         <= op_add_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            busy_q           <= busy_d;
        end
    end

    // Pixel buffer: one shared port, registered read, contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata_q <= mem[mem_addr];
    end

    // Next-state logic; CLR_PTR returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (cmd_clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_WRITE: begin
                    if (cmd_accept) begin
                        case (cmd_in)
                            CMD_WRITE:  state_d = S_WRITE;
                            CMD_READ:   state_d = S_RD_ADDR;
                            CMD_INVERT: state_d = S_OP_RD;
                            CMD_ADD:    state_d = S_ARG_WAIT;
                            default:    state_d = state_q;
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                S_ARG_WAIT: state_d = data_ok ? S_OP_RD : S_ARG_WAIT;
                S_OP_RD:    state_d = S_OP_WAIT;
                S_OP_WAIT:  state_d = S_OP_WR;
                S_OP_WR:    state_d = (op_addr_q == PTR_LAST) ? S_IDLE : S_OP_RD;
                S_RD_ADDR:  state_d = S_RD_WAIT;
                S_RD_WAIT:  state_d = S_RD_SEND;
                S_RD_SEND: begin
                    if (send_ok) begin
                        state_d = (rd_ptr_q == PTR_LAST) ? S_IDLE : S_RD_ADDR;
                    end else begin
                        state_d = S_RD_SEND;
                    end
                end
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath logic: pointers, BRAM port control, return byte, busy.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        op_addr_d        = op_addr_q;
        operand_d        = operand_q;
        op_add_d         = op_add_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        mem_addr         = wr_ptr_q;
        mem_we           = 1'b0;
        mem_wdata        = data_in;

        if (cmd_accept) begin
            case (cmd_in)
                CMD_READ:   rd_ptr_d = PTR_ZERO;
                CMD_INVERT: begin
                    op_addr_d = PTR_ZERO;
                    op_add_d  = 1'b0;
                end
                default:    op_add_d = op_add_q;
            endcase
        end else begin
            op_add_d = op_add_q;
        end

        case (state_q)
            S_WRITE: begin
                mem_addr = wr_ptr_q;
                if (data_ok) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end else begin
                    mem_we   = 1'b0;
                end
            end
            S_ARG_WAIT: begin
                if (data_ok) begin
                    operand_d = data_in;
                    op_addr_d = PTR_ZERO;
                    op_add_d  = 1'b1;
                end else begin
                    operand_d = operand_q;
                end
            end
            S_OP_RD, S_OP_WAIT: mem_addr = op_addr_q;
            S_OP_WR: begin
                mem_addr  = op_addr_q;
                mem_wdata = op_result;
                mem_we    = !cmd_clr;
                op_addr_d = op_addr_q + PTR_ONE;
            end
            S_RD_ADDR, S_RD_WAIT: mem_addr = rd_ptr_q;
            S_RD_SEND: begin
                mem_addr = rd_ptr_q;
                if (send_ok && !cmd_clr) begin
                    data_out_valid_d = 1'b1;
                    data_out_d       = mem_rdata_q;
                    rd_ptr_d         = rd_ptr_q + PTR_ONE;
                end else begin
                    data_out_valid_d = 1'b0;
                end
            end
            default: mem_we = 1'b0;
        endcase

        if (cmd_clr) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
        end else begin
            wr_ptr_d = wr_ptr_d;
        end

        case (state_d)
            S_ARG_WAIT, S_OP_RD, S_OP_WAIT, S_OP_WR,
            S_RD_ADDR, S_RD_WAIT, S_RD_SEND: busy_d = 1'b1;
            default:                         busy_d = 1'b0;
        endcase
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_spi_pixel_buffer_ctrl.sv
// Scoreboard bench for spi_pixel_buffer_ctrl: a model buffer tracks writes and
// point operations, READ pushes the expected 256 bytes, the monitor pops them.
module tb_spi_pixel_buffer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cmd_in;
    logic       cmd_valid;
    logic [7:0] data_in;
    logic       data_valid;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_free;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [0:255];
    logic [7:0] model_wr;
    logic [7:0] exp_q [$];
    int         pulses = 0;
    int         cyc = 0;
    int         last_pulse = -1000;
    logic       free_last = 1'b1;

    spi_pixel_buffer_ctrl #(.ADDR_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_in         (cmd_in),
        .cmd_valid      (cmd_valid),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_free  (data_out_free),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every return pulse and checks pacing.
    always @(negedge clk) begin
        cyc++;
        if (data_out_valid) begin
            pulses++;
            check_eq("pulse_free", {31'd0, free_last}, 32'd1);
            check_eq("pulse_gap", {31'd0, (cyc - last_pulse) >= 2}, 32'd1);
            last_pulse = cyc;
            check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("rd_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
        free_last = data_out_free;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        tick();
        cmd_in = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        tick();
        data_in = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic send_clr();
        send_cmd(8'h01);
        model_wr = 8'h00;
    endtask

    task automatic write_byte(input logic [7:0] d);
        send_data(d);
        model_mem[model_wr] = d;
        model_wr = model_wr + 8'd1;
    endtask

    task automatic wait_op(input string tag);
        int cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            tick();
        end
        check_eq(tag, cnt, 32'd768);
    endtask

    task automatic do_invert();
        send_cmd(8'h04);
        wait_op("inv_busy_cycles");
        for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF - model_mem[i];
    endtask

    task automatic do_add(input logic [7:0] op);
        logic [8:0] s;
        send_cmd(8'h05);
        check_eq("argwait_busy", {31'd0, busy}, 32'd1);
        send_data(op);
        wait_op("add_busy_cycles");
        for (int i = 0; i < 256; i++) begin
            s = {1'b0, model_mem[i]} + {1'b0, op};
            model_mem[i] = s[8] ? 8'hFF : s[7:0];
        end
    endtask

    task automatic do_read(input bit hold);
        int p0;
        int cnt;
        for (int i = 0; i < 256; i++) exp_q.push_back(model_mem[i]);
        p0 = pulses;
        send_cmd(8'h03);
        check_eq("rd_busy", {31'd0, busy}, 32'd1);
        if (hold) begin
            cnt = 0;
            while (pulses == p0 && cnt < 100) begin
                cnt++;
                tick();
            end
            data_out_free = 1'b0;
            repeat (50) tick();
            check_eq("hold_pulses", pulses - p0, 32'd1);
            data_out_free = 1'b1;
        end
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            tick();
        end
        check_eq("rd_done", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        check_eq("rd_pulse_count", pulses - p0, 32'd256);
        check_eq("sb_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cmd_in = 8'h00;
        cmd_valid = 1'b0;
        data_in = 8'h00;
        data_valid = 1'b0;
        data_out_free = 1'b1;
        model_wr = 8'h00;
        repeat (3) tick();
        check_eq("rst_data_out", {24'd0, data_out}, 32'd0);
        check_eq("rst_valid", {31'd0, data_out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Fill the whole buffer so every later read has a known image.
        send_clr();
        send_cmd(8'h02);
        for (int i = 0; i < 256; i++) write_byte(8'(i * 7 + 3));

        // Basic write then full read-back.
        send_clr();
        send_cmd(8'h02);
        write_byte(8'h10);
        write_byte(8'h20);
        write_byte(8'h30);
        do_read(1'b0);

        // Invert pass.
        send_clr();
        send_cmd(8'h02);
        write_byte(8'h00);
        write_byte(8'h7F);
        write_byte(8'hFF);
        do_invert();
        check_eq("inv_model0", {24'd0, model_mem[0]}, 32'hFF);
        do_read(1'b0);

        // Saturating add pass.
        send_clr();
        send_cmd(8'h02);
        write_byte(8'h10);
        write_byte(8'hF0);
        do_add(8'h20);
        check_eq("add_model1", {24'd0, model_mem[1]}, 32'hFF);
        do_read(1'b0);

        // Back-pressure: free held low after the first byte.
        do_read(1'b1);

        // Reset in the middle of an invert pass.
        send_cmd(8'h04);
        repeat (300) tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_valid", {31'd0, data_out_valid}, 32'd0);
        reset = 1'b0;
        model_wr = 8'h00;
        repeat (5) tick();
        check_eq("midrst_quiet", {31'd0, data_out_valid}, 32'd0);

        // Wrap of the write pointer, then a command+data collision in IDLE.
        send_clr();
        send_cmd(8'h02);
        for (int i = 0; i < 256; i++) write_byte(8'(i));
        write_byte(8'hAA);
        check_eq("wrap_model0", {24'd0, model_mem[0]}, 32'hAA);
        send_clr();
        tick();
        cmd_in = 8'h00;
        cmd_valid = 1'b1;
        data_in = 8'h55;
        data_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        data_valid = 1'b0;
        do_read(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
